data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, sets the word-address width.
REQ-002 Parameter DATA_W, default 32, sets the data width.
REQ-003 Parameter LOCK_MAX, default 16, sets the maximum number of consecutive cycles a port-B lock may hold the memory.
REQ-004 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 a_req  in  1  port A (CPU) access request.
REQ-008 a_we  in  4  port A byte-write bitmap (bit3 = bits 7:0 ... bit0 = bits 31:24); 0 means read.
REQ-009 a_addr  in  ADDR_W  port A word address.
REQ-010 a_wdata  in  DATA_W  port A write data.
REQ-011 a_gnt  out  1  port A access issued this cycle.
REQ-012 a_rvalid  out  1  port A read data valid.
REQ-013 a_rdata  out  DATA_W  port A read data.
REQ-014 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same widths and meanings as the port A signals, for port B (DMA/debug).
REQ-015 b_lock  in  1  port B requests exclusive ownership, used for read-modify-write.
REQ-016 mem_en  out  1  data-memory chip enable.
REQ-017 mem_we  out  4  data-memory write bitmap.
REQ-018 mem_addr  out  ADDR_W  data-memory address.
REQ-019 mem_wdata  out  DATA_W  data-memory write data.
REQ-020 mem_rdata  in  DATA_W  data-memory read data, registered, valid one cycle after mem_en.

Function
REQ-021 The arbiter SHALL be an FSM with states IDLE, OWN_A, OWN_B and LOCK_B, advancing on the rising edge of clk.
REQ-022 Grant is combinational within a cycle: a_gnt/b_gnt SHALL assert in the same cycle the winning request is driven onto mem_*; a_gnt and b_gnt are never both 1.
REQ-023 Tie (a_req and b_req both 1, no active lock): the grant SHALL go to the port not granted last (round-robin), using a last_gnt register.
REQ-024 A single requester SHALL be granted every cycle it requests, with zero bubbles.
REQ-025 No requester: mem_en=0, mem_we=0, and the FSM goes to IDLE.
REQ-026 mem_we SHALL equal the granted port's bitmap, and mem_addr/mem_wdata its address and data; with no grant, mem_we is forced to 0.
REQ-027 Each grant SHALL set a one-cycle-delayed tag (rv_a/rv_b) for reads and writes alike; in the next cycle, x_rvalid=1 and x_rdata=mem_rdata for the tagged port only.
REQ-028 The non-tagged port's x_rdata SHALL hold its last valid value.
REQ-029 A granted b_req with b_lock=1 SHALL enter LOCK_B.
REQ-030 In LOCK_B, port A SHALL receive no grant, even if requesting.
REQ-031 LOCK_B SHALL be left when b_lock=0 or when lock_cnt reaches LOCK_MAX; on a forced release, a pending a_req SHALL be granted next.
REQ-032 lock_cnt SHALL be a saturating counter, cleared on LOCK_B entry.
REQ-033 Requests SHALL be sampled only in the cycle presented: a requester not granted must hold req/addr/we/wdata stable until granted.

Reset
REQ-034 rst SHALL be sampled on the rising edge of clk; while high, the FSM is IDLE.
REQ-035 During reset: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, mem_en=0, mem_we=0.
REQ-036 Reset values: last_gnt=B (so port A wins the first tie), lock_cnt=0, rdata registers=0.
REQ-037 A reset asserted mid-lock or with a read in flight SHALL drop the lock and suppress the pending rvalid.

Structure
REQ-038 The FSM state encoding and the port-ID constants (PORT_A, PORT_B) SHALL live in the shared CPU package.
REQ-039 The block SHALL contain no sub-modules; the memory itself is instantiated by the parent, not inside the arbiter.

Verification
REQ-040 Only a_req, a_we=4'b1111, addr=0x010, wdata=0xDEADBEEF, then a read of 0x010 -> a_gnt in both cycles; a_rvalid with a_rdata=0xDEADBEEF one cycle after the read grant.
REQ-041 a_req and b_req both held 4 cycles after reset -> grant order A,B,A,B; rvalid follows each grant by one cycle on the matching port only.
REQ-042 b_req+b_lock for 3 cycles while a_req=1 -> b_gnt x3, a_gnt=0 during the lock, a_gnt in the cycle after b_lock drops.
REQ-043 b_lock held 20 cycles with LOCK_MAX=16 -> forced release after 16 B grants; a_gnt next cycle.
REQ-044 b_we=4'b0100 at addr 0x7FF with wdata=0x00AA5500 -> mem_we=4'b0100 and mem_addr=0x7FF in the grant cycle; no wrap or truncation of the address.
REQ-045 rst asserted during LOCK_B with a read in flight -> next cycle all gnt/rvalid=0; after rst drops, a tie is granted to A.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port IDs.
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_A  = 2'd1,
      OWN_B  = 2'd2,
      LOCK_B = 2'd3
   } arb_state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_id_e;

   localparam int WE_W = 4;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-port data-memory arbiter: round-robin between CPU (A) and DMA/debug (B),
// with a bounded exclusive lock for port B read-modify-write sequences.
//
// state  | meaning
// IDLE   | no access issued last cycle
// OWN_A  | port A was granted last cycle
// OWN_B  | port B was granted last cycle (unlocked)
// LOCK_B | port B holds the memory exclusively; port A is blocked
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [WE_W-1:0]   a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_lock,
   input  logic [WE_W-1:0]   b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_en,
   output logic [WE_W-1:0]   mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   arb_state_e        state_q, state_d;
   port_id_e          last_gnt_q;
   logic [CNT_W-1:0]  lock_cnt_q;
   logic              rv_a_q, rv_b_q;
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
   logic              gnt_a, gnt_b;
   logic              lock_held, lock_enter;

   // The entry grant counts as the first of LOCK_MAX locked grants, so the lock
   // holds while lock_cnt (grants inside LOCK_B) is below LOCK_MAX-1.
   assign lock_held  = (state_q == LOCK_B) && b_lock && (lock_cnt_q < CNT_LAST);
   assign lock_enter = gnt_b && b_lock && !lock_held;

   always_comb begin
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      state_d = IDLE;
      if (!rst) begin
         if (lock_held) begin
            gnt_b   = b_req;
            state_d = LOCK_B;
         end else begin
            if (state_q == LOCK_B && a_req) begin
               gnt_a = 1'b1;
            end else if (a_req && b_req) begin
               if (last_gnt_q == PORT_B) gnt_a = 1'b1;
               else                      gnt_b = 1'b1;
            end else begin
               gnt_a = a_req;
               gnt_b = b_req;
            end
            if (gnt_a)      state_d = OWN_A;
            else if (gnt_b) state_d = b_lock ? LOCK_B : OWN_B;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= PORT_B;
         lock_cnt_q <= '0;
         rv_a_q     <= 1'b0;
         rv_b_q     <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (gnt_a)      last_gnt_q <= PORT_A;
         else if (gnt_b) last_gnt_q <= PORT_B;
         if (lock_enter)
            lock_cnt_q <= '0;
         else if (lock_held && lock_cnt_q < CNT_MAX)
            lock_cnt_q <= lock_cnt_q + 1'b1;
         rv_a_q <= gnt_a;
         rv_b_q <= gnt_b;
         if (rv_a_q) a_rdata_q <= mem_rdata;
         if (rv_b_q) b_rdata_q <= mem_rdata;
      end
   end

   assign a_gnt     = gnt_a;
   assign b_gnt     = gnt_b;
   assign mem_en    = gnt_a | gnt_b;
   assign mem_we    = gnt_b ? b_we : (gnt_a ? a_we : '0);
   assign mem_addr  = gnt_b ? b_addr : a_addr;
   assign mem_wdata = gnt_b ? b_wdata : a_wdata;

   // Read data is passed straight through in the tagged cycle and held after.
   assign a_rvalid = rv_a_q & ~rst;
   assign b_rvalid = rv_b_q & ~rst;
   assign a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
   assign b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a registered-read byte-write memory model.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req, b_lock;
   logic [3:0]  a_we, b_we;
   logic [10:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [31:0] a_rdata, b_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [10:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] mem [0:2047];
   int errs   = 0;
   int checks = 0;
   int b_cnt;

   always #5 clk = ~clk;

   data_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .LOCK_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // bitmap bit3 writes bits 7:0 ... bit0 writes bits 31:24
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         if (mem_we[3]) mem[mem_addr][7:0]   <= mem_wdata[7:0];
         if (mem_we[2]) mem[mem_addr][15:8]  <= mem_wdata[15:8];
         if (mem_we[1]) mem[mem_addr][23:16] <= mem_wdata[23:16];
         if (mem_we[0]) mem[mem_addr][31:24] <= mem_wdata[31:24];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_lock = 0; b_we = 0; b_addr = 0; b_wdata = 0;
   endtask

   // inputs change at the falling edge, outputs checked 1ns later
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      mem_rdata = 32'h0;
      quiet();
      rst = 1;
      cyc();
      a_req = 1; b_req = 1; a_we = 4'hF;
      #1;
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      chk("rst_rdata", {a_rdata, b_rdata}, 0);

      // single requester: write then read back
      cyc(); rst = 0; quiet();
      a_req = 1; a_we = 4'hF; a_addr = 11'h010; a_wdata = 32'hDEADBEEF;
      #1;
      chk("wr_a_gnt", a_gnt, 1);
      chk("wr_mem_we", mem_we, 4'hF);
      chk("wr_mem_addr", mem_addr, 11'h010);
      cyc(); a_we = 0;
      #1;
      chk("rd_a_gnt", a_gnt, 1);
      chk("rd_wr_rvalid", a_rvalid, 1);
      cyc(); quiet(); a_we = 4'hF;
      #1;
      chk("rd_a_rvalid", a_rvalid, 1);
      chk("rd_a_rdata", a_rdata, 32'hDEADBEEF);
      chk("idle_mem_en", mem_en, 0);
      chk("idle_mem_we", mem_we, 0);
      cyc(); quiet();
      #1;
      chk("hold_a_rvalid", a_rvalid, 0);
      chk("hold_a_rdata", a_rdata, 32'hDEADBEEF);

      // preload for port B, then reset so the tie starts from last_gnt=B
      cyc(); b_req = 1; b_we = 4'hF; b_addr = 11'h002; b_wdata = 32'h22222222;
      #1;
      chk("pre_b_gnt", b_gnt, 1);
      cyc(); quiet(); rst = 1;
      cyc(); rst = 0;
      for (int i = 0; i < 4; i++) begin
         a_req = 1; a_addr = 11'h010;
         b_req = 1; b_addr = 11'h002;
         #1;
         chk($sformatf("tie%0d_a_gnt", i), a_gnt, (i % 2 == 0));
         chk($sformatf("tie%0d_b_gnt", i), b_gnt, (i % 2 == 1));
         if (i > 0) begin
            chk($sformatf("tie%0d_a_rvalid", i), a_rvalid, ((i - 1) % 2 == 0));
            chk($sformatf("tie%0d_b_rvalid", i), b_rvalid, ((i - 1) % 2 == 1));
         end
         if (i == 1) chk("tie1_a_rdata", a_rdata, 32'hDEADBEEF);
         cyc();
      end
      quiet();
      #1;
      chk("tie_end_b_rvalid", b_rvalid, 1);
      chk("tie_end_a_rvalid", a_rvalid, 0);
      chk("tie_end_b_rdata", b_rdata, 32'h22222222);
      chk("tie_end_a_rdata", a_rdata, 32'hDEADBEEF);

      // short lock dropped voluntarily
      cyc(); b_req = 1; b_lock = 1; b_addr = 11'h002;
      #1;
      chk("lk_b_gnt0", b_gnt, 1);
      for (int i = 1; i < 3; i++) begin
         cyc(); a_req = 1;
         #1;
         chk($sformatf("lk_b_gnt%0d", i), b_gnt, 1);
         chk($sformatf("lk_a_blk%0d", i), a_gnt, 0);
      end
      cyc(); b_req = 0; b_lock = 0;
      #1;
      chk("lk_rel_a_gnt", a_gnt, 1);
      chk("lk_rel_b_gnt", b_gnt, 0);
      cyc(); quiet();

      // lock held too long: forced release after 16 B grants
      b_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         b_req = 1; b_lock = 1; b_addr = 11'h002;
         a_req = (i > 0);
         #1;
         if (i < 16) begin
            b_cnt += int'(b_gnt);
            chk($sformatf("fl%0d_a_blk", i), a_gnt, 0);
         end
         if (i == 16) begin
            chk("fl_b_count", b_cnt, 16);
            chk("fl_rel_a_gnt", a_gnt, 1);
            chk("fl_rel_b_gnt", b_gnt, 0);
         end
      end
      cyc(); quiet();
      cyc();

      // top-of-range address, single byte lane
      cyc(); b_req = 1; b_we = 4'b0100; b_addr = 11'h7FF; b_wdata = 32'h00AA5500;
      #1;
      chk("hi_b_gnt", b_gnt, 1);
      chk("hi_mem_we", mem_we, 4'b0100);
      chk("hi_mem_addr", mem_addr, 11'h7FF);
      chk("hi_mem_wdata", mem_wdata, 32'h00AA5500);
      cyc(); b_we = 0;
      cyc(); quiet();
      #1;
      chk("hi_b_rdata", b_rdata, 32'h00005500);

      // reset in the middle of a lock with a read in flight
      cyc(); b_req = 1; b_lock = 1; b_addr = 11'h002;
      #1;
      chk("rl_b_gnt", b_gnt, 1);
      cyc(); rst = 1; a_req = 1;
      #1;
      chk("rl_rst_gnt", {a_gnt, b_gnt}, 0);
      chk("rl_rst_rvalid", {a_rvalid, b_rvalid}, 0);
      chk("rl_rst_mem_en", mem_en, 0);
      cyc(); rst = 0;
      #1;
      chk("rl_tie_a_gnt", a_gnt, 1);
      chk("rl_tie_b_gnt", b_gnt, 0);
      chk("rl_no_rvalid", {a_rvalid, b_rvalid}, 0);
      cyc(); quiet();
      cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
